// File: rtl/and_gate_bank.sv
// Run-time selectable AND/NAND/OR/NOR gate bank with registered outputs and a
// built-in self-test sequencer that sweeps every operand pattern through every mode.
module and_gate_lane #(
    parameter int INPUTS = 3
) (
    input  logic [INPUTS-1:0] in_ops,
    input  logic [1:0]        in_mode,
    input  logic              in_inv,
    output logic              out_y
);
    logic w_f;

    always_comb begin
        w_f = 1'b0;
        case (in_mode)
            2'b00:   w_f = &in_ops;
            2'b01:   w_f = ~&in_ops;
            2'b10:   w_f = |in_ops;
            default: w_f = ~|in_ops;
        endcase
    end

    assign out_y = w_f ^ in_inv;
endmodule

module and_gate_bank #(
    parameter int CHANNELS = 3,
    parameter int INPUTS   = 3
) (
    input  logic                         in_clk,
    input  logic                         in_rst_n,
    input  logic [CHANNELS*INPUTS-1:0]   in_data,
    input  logic [1:0]                   in_mode,
    input  logic                         in_en,
    input  logic [CHANNELS-1:0]          in_fault_inj,
    input  logic                         in_bist_start,
    output logic [CHANNELS-1:0]          out_y,
    output logic                         out_valid,
    output logic                         out_bist_busy,
    output logic                         out_bist_done,
    output logic [CHANNELS-1:0]          out_bist_fail
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [INPUTS-1:0]   r_pat;
    logic [1:0]          r_bmode;
    logic [INPUTS-1:0]   r_dpat;
    logic [1:0]          r_dmode;
    logic [CHANNELS-1:0] r_bist_y;
    logic                r_cap_vld;
    logic [CHANNELS-1:0] r_y;
    logic                r_valid;
    logic [CHANNELS-1:0] r_fail;

    logic                w_run;
    logic [1:0]          w_mode;
    logic [CHANNELS-1:0] w_y_raw;
    logic                w_gold;
    logic [CHANNELS-1:0] w_miss;
    logic                w_last;

    assign w_run  = (r_state == S_RUN);
    assign w_mode = w_run ? r_bmode : in_mode;
    assign w_last = (&r_pat) && (r_bmode == 2'd3);

    // While RUN owns the core, every lane sees the sweep pattern instead of in_data.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        and_gate_lane #(.INPUTS(INPUTS)) u_lane (
            .in_ops  (w_run ? r_pat : in_data[c*INPUTS +: INPUTS]),
            .in_mode (w_mode),
            .in_inv  (in_fault_inj[c]),
            .out_y   (w_y_raw[c])
        );
    end

    // Reference result for the capture taken one edge earlier.
    and_gate_lane #(.INPUTS(INPUTS)) u_gold (
        .in_ops  (r_dpat),
        .in_mode (r_dmode),
        .in_inv  (1'b0),
        .out_y   (w_gold)
    );

    assign w_miss = r_bist_y ^ {CHANNELS{w_gold}};

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state   <= S_IDLE;
            r_pat     <= '0;
            r_bmode   <= '0;
            r_dpat    <= '0;
            r_dmode   <= '0;
            r_bist_y  <= '0;
            r_cap_vld <= 1'b0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_fail    <= '0;
        end else begin
            if (r_cap_vld)
                r_fail <= r_fail | w_miss;
            case (r_state)
                S_IDLE: begin
                    if (in_bist_start) begin
                        r_state   <= S_RUN;
                        r_fail    <= '0;
                        r_pat     <= '0;
                        r_bmode   <= '0;
                        r_cap_vld <= 1'b0;
                        r_valid   <= 1'b0;
                    end else if (in_en) begin
                        r_y     <= w_y_raw;
                        r_valid <= 1'b1;
                    end else begin
                        r_valid <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_valid   <= 1'b0;
                    r_bist_y  <= w_y_raw;
                    r_dpat    <= r_pat;
                    r_dmode   <= r_bmode;
                    r_cap_vld <= 1'b1;
                    r_pat     <= r_pat + INPUTS'(1);
                    if (&r_pat)
                        r_bmode <= r_bmode + 2'd1;
                    if (w_last)
                        r_state <= S_DRAIN;
                end
                S_DRAIN: begin
                    r_valid   <= 1'b0;
                    r_cap_vld <= 1'b0;
                    r_state   <= S_DONE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_y         = r_y;
    assign out_valid     = r_valid;
    assign out_bist_busy = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign out_bist_done = (r_state == S_DONE);
    assign out_bist_fail = r_fail;
endmodule

// File: tb/tb_and_gate_bank.sv
// Directed-vector bench for and_gate_bank (3 channels x 3 inputs): functional
// gate modes, hold behaviour, BIST timing/fault detection and reset abort.
module tb_and_gate_bank;
    localparam int CH = 3;
    localparam int IN = 3;

    logic              clk;
    logic              rst_n;
    logic [CH*IN-1:0]  data;
    logic [1:0]        mode;
    logic              en;
    logic [CH-1:0]     inj;
    logic              start;
    logic [CH-1:0]     y;
    logic              valid;
    logic              busy;
    logic              done;
    logic [CH-1:0]     fail;

    int n_vec;
    int n_err;

    and_gate_bank #(.CHANNELS(CH), .INPUTS(IN)) dut (
        .in_clk        (clk),
        .in_rst_n      (rst_n),
        .in_data       (data),
        .in_mode       (mode),
        .in_en         (en),
        .in_fault_inj  (inj),
        .in_bist_start (start),
        .out_y         (y),
        .out_valid     (valid),
        .out_bist_busy (busy),
        .out_bist_done (done),
        .out_bist_fail (fail)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic func_vec(input string tag, input logic [1:0] m, input logic [CH*IN-1:0] d,
                            input logic [CH-1:0] fi, input logic [CH-1:0] exp_y);
        mode = m; data = d; inj = fi; en = 1'b1;
        tick();
        chk({tag, "_y"}, 32'(y), 32'(exp_y));
        chk({tag, "_valid"}, 32'(valid), 32'd1);
        en = 1'b0; inj = '0;
    endtask

    // Starts BIST and watches it for 40 cycles; a second start while busy must be ignored.
    task automatic run_bist(input string tag, input logic [CH-1:0] fi, input logic [CH-1:0] exp_fail);
        int busy_n;
        int done_at;
        int done_n;
        int bad_fz;
        logic [CH-1:0] y0;
        busy_n = 0; done_at = -1; done_n = 0; bad_fz = 0;
        y0 = y;
        inj = fi; en = 1'b1; data = 9'b101_010_110; mode = 2'b10;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_fail_clr"}, 32'(fail), 32'd0);
        for (int i = 0; i < 40; i++) begin
            if (busy) busy_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if ((busy || done) && (valid || y !== y0)) bad_fz++;
            data = 9'(i * 37);
            mode = 2'(i);
            start = (i == 5);
            tick();
        end
        start = 1'b0; en = 1'b0;
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd33);
        chk({tag, "_done_at"}, 32'(done_at), 32'd33);
        chk({tag, "_done_width"}, 32'(done_n), 32'd1);
        chk({tag, "_frozen"}, 32'(bad_fz), 32'd0);
        chk({tag, "_fail"}, 32'(fail), 32'(exp_fail));
        inj = '0;
    endtask

    initial begin
        int dn;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; start = 1'b0;
        data = 9'($urandom); mode = 2'($urandom); en = 1'b1; inj = 3'($urandom);
        // T1 reset
        #23;
        chk("rst_y", 32'(y), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        en = 1'b0; inj = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_valid", 32'(valid), 32'd0);

        // T2 functional modes
        func_vec("and",   2'b00, 9'b111_011_111, 3'b000, 3'b101);
        func_vec("nand0", 2'b01, 9'b000_000_000, 3'b000, 3'b111);
        func_vec("nand",  2'b01, 9'b111_000_111, 3'b000, 3'b010);
        func_vec("or0",   2'b10, 9'b000_000_000, 3'b000, 3'b000);
        func_vec("or",    2'b10, 9'b000_100_000, 3'b000, 3'b010);
        func_vec("nor0",  2'b11, 9'b000_000_000, 3'b000, 3'b111);
        func_vec("nor",   2'b11, 9'b001_000_010, 3'b000, 3'b010);
        func_vec("inj",   2'b00, 9'b111_011_111, 3'b011, 3'b110);
        func_vec("and1",  2'b00, 9'b011_111_110, 3'b000, 3'b010);

        // T3 hold with en=0
        en = 1'b0; data = 9'b111_111_111; mode = 2'b11;
        tick();
        chk("hold_y", 32'(y), 32'b010);
        chk("hold_valid", 32'(valid), 32'd0);
        data = 9'b000_000_000;
        tick();
        chk("hold_y2", 32'(y), 32'b010);

        // T4 / T5 BIST
        run_bist("bist_clean", 3'b000, 3'b000);
        run_bist("bist_inj",   3'b010, 3'b010);
        run_bist("bist_again", 3'b000, 3'b000);

        // T6 reset mid-BIST
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("abort_pre_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done || busy) dn++;
        end
        chk("abort_quiet", 32'(dn), 32'd0);
        run_bist("bist_restart", 3'b000, 3'b000);

        // Functional path still works after BIST
        func_vec("post", 2'b00, 9'b111_111_111, 3'b000, 3'b111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
